// File: rtl/filter_ctrl_pkg.sv
// Shared types and widths for the filter chain frame sequencer.
package filter_ctrl_pkg;

  localparam int CFG_W_DEF   = 4;
  localparam int FRAME_CNT_W = 8;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_BEGIN,
    ST_WAIT_DONE,
    ST_DRAIN,
    ST_GAP
  } seq_state_t;

endpackage

// File: rtl/seq_cycle_counter.sv
// Loadable down-counter; tc flags the final counted cycle (count == 1).
// Latency: load visible next cycle; tc is combinational from the count.
// Backpressure: none; en simply holds the count when low.
module seq_cycle_counter #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         en,
  output logic         tc
);

  logic [W-1:0] count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (en && (count != '0)) begin
      count <= count - W'(1);
    end
  end

  assign tc = (count == W'(1));

endmodule

// File: rtl/filter_frame_sequencer.sv
// Sequences multi-frame runs: src_begin pulse, wait src_done edge, wait filter drain, frame gap.
// Latency: start -> src_begin 2 cycles; frame_tick/seq_done one cycle after the last quiet cycle.
// Backpressure: none; start while busy is dropped, abort is latched and honoured at frame drain.
module filter_frame_sequencer
  import filter_ctrl_pkg::*;
#(
  parameter int BEGIN_PULSE = 5,
  parameter int DRAIN_IDLE  = 64,
  parameter int FRAME_GAP   = 16,
  parameter int CFG_W       = CFG_W_DEF,
  parameter int TMO_W       = 24
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic                   abort,
  input  logic [FRAME_CNT_W-1:0] num_frames,
  input  logic [CFG_W-1:0]       cfg_in,
  output logic [CFG_W-1:0]       cfg_active,
  output logic                   src_begin,
  input  logic                   src_done,
  input  logic                   post_valid,
  output logic                   busy,
  output logic [FRAME_CNT_W-1:0] frame_idx,
  output logic                   frame_tick,
  output logic                   seq_done,
  output logic                   timeout_err
);

  localparam int PULSE_W = $clog2(BEGIN_PULSE + 1);
  localparam int GAP_W   = $clog2(FRAME_GAP + 1);
  localparam int IDLE_W  = $clog2(DRAIN_IDLE + 1);
  localparam logic [TMO_W-1:0] WD_LAST = {{(TMO_W-1){1'b1}}, 1'b0};

  seq_state_t state, next_state;

  logic [FRAME_CNT_W-1:0] frames_left;
  logic                   continuous;
  logic                   abort_q;
  logic                   done_q;
  logic [TMO_W-1:0]       wd_cnt;

  logic pulse_load, gap_load, idle_load;
  logic pulse_tc, gap_tc, idle_tc;
  logic done_rise, abort_eff, last_frame;
  logic wd_active, wd_expire;
  logic frame_done, run_complete, to_gap;

  assign done_rise  = src_done & ~done_q;
  assign abort_eff  = abort_q | abort;
  assign last_frame = !continuous && (frames_left == FRAME_CNT_W'(1));
  assign wd_active  = (state == ST_BEGIN) || (state == ST_WAIT_DONE) || (state == ST_DRAIN);
  // Fires one cycle early so timeout_err lands on the same edge the counter saturates.
  assign wd_expire  = wd_active && (wd_cnt == WD_LAST);

  seq_cycle_counter #(.W(PULSE_W)) u_pulse_cnt (
    .clk      (clk),
    .rst      (rst),
    .load     (pulse_load),
    .load_val (PULSE_W'(BEGIN_PULSE)),
    .en       (state == ST_BEGIN),
    .tc       (pulse_tc)
  );

  seq_cycle_counter #(.W(GAP_W)) u_gap_cnt (
    .clk      (clk),
    .rst      (rst),
    .load     (gap_load),
    .load_val (GAP_W'(FRAME_GAP)),
    .en       (state == ST_GAP),
    .tc       (gap_tc)
  );

  seq_cycle_counter #(.W(IDLE_W)) u_idle_cnt (
    .clk      (clk),
    .rst      (rst),
    .load     (idle_load),
    .load_val (IDLE_W'(DRAIN_IDLE)),
    .en       ((state == ST_DRAIN) && !post_valid),
    .tc       (idle_tc)
  );

  always_comb begin
    next_state   = state;
    pulse_load   = 1'b0;
    gap_load     = 1'b0;
    idle_load    = 1'b0;
    frame_done   = 1'b0;
    run_complete = 1'b0;
    to_gap       = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (start) next_state = ST_LOAD;
      end
      ST_LOAD: begin
        pulse_load = 1'b1;
        next_state = ST_BEGIN;
      end
      ST_BEGIN: begin
        if (pulse_tc) next_state = ST_WAIT_DONE;
      end
      ST_WAIT_DONE: begin
        if (done_rise) begin
          idle_load  = 1'b1;
          next_state = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (post_valid) begin
          idle_load = 1'b1;
        end else if (idle_tc) begin
          frame_done = 1'b1;
          if (abort_eff) begin
            next_state = ST_IDLE;
          end else if (last_frame) begin
            run_complete = 1'b1;
            next_state   = ST_IDLE;
          end else begin
            to_gap     = 1'b1;
            gap_load   = 1'b1;
            next_state = ST_GAP;
          end
        end
      end
      ST_GAP: begin
        if (gap_tc) next_state = ST_LOAD;
      end
      default: next_state = ST_IDLE;
    endcase
    if (wd_expire) begin
      next_state   = ST_IDLE;
      frame_done   = 1'b0;
      run_complete = 1'b0;
      to_gap       = 1'b0;
      gap_load     = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ST_IDLE;
      src_begin  <= 1'b0;
      busy       <= 1'b0;
      frame_tick <= 1'b0;
      seq_done   <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state      <= next_state;
      src_begin  <= (next_state == ST_BEGIN);
      busy       <= (next_state != ST_IDLE);
      frame_tick <= frame_done;
      seq_done   <= run_complete;
      done_q     <= src_done;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      frames_left <= '0;
      continuous  <= 1'b0;
      abort_q     <= 1'b0;
      frame_idx   <= '0;
      timeout_err <= 1'b0;
    end else if ((state == ST_IDLE) && start) begin
      frames_left <= num_frames;
      continuous  <= (num_frames == '0);
      abort_q     <= 1'b0;
      frame_idx   <= '0;
      timeout_err <= 1'b0;
    end else begin
      if ((state != ST_IDLE) && abort) abort_q <= 1'b1;
      if (to_gap && !continuous) frames_left <= frames_left - FRAME_CNT_W'(1);
      // Advance the index in the first gap cycle so frame_tick reports the frame just drained.
      if (frame_tick && (state == ST_GAP)) frame_idx <= frame_idx + FRAME_CNT_W'(1);
      if (wd_expire) timeout_err <= 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cfg_active <= '0;
      wd_cnt     <= '0;
    end else begin
      if (state == ST_LOAD) cfg_active <= cfg_in;
      if (pulse_load) begin
        wd_cnt <= '0;
      end else if (wd_active && (wd_cnt != '1)) begin
        wd_cnt <= wd_cnt + TMO_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_filter_frame_sequencer.sv
// Directed bench for filter_frame_sequencer with a behavioural frame source / filter output model.
module tb_filter_frame_sequencer;

  localparam int BEGIN_PULSE = 5;
  localparam int DRAIN_IDLE  = 64;
  localparam int FRAME_GAP   = 16;
  localparam int CFG_W       = 4;
  localparam int TMO_W       = 8;

  logic             clk = 1'b0;
  logic             rst, start, abort, src_done, post_valid;
  logic [7:0]       num_frames, frame_idx;
  logic [CFG_W-1:0] cfg_in, cfg_active;
  logic             src_begin, busy, frame_tick, seq_done, timeout_err;

  int errors = 0;
  int checks = 0;

  int done_delay  = 100;
  int burst_pre   = 5;
  int burst_len   = 10;
  bit toggle_mode = 1'b0;
  bit src_en      = 1'b1;

  int cyc = 0, begin_cnt = 0, bad_len = 0, cur_len = 0;
  int tick_cnt = 0, done_cnt = 0, last_tick_cyc = 0, pv_fall_cyc = 0;
  logic [7:0] tick_idx [0:255];
  logic sb_q = 1'b0;
  logic m_prev = 1'b0;

  always #5 clk = ~clk;

  filter_frame_sequencer #(
    .BEGIN_PULSE (BEGIN_PULSE),
    .DRAIN_IDLE  (DRAIN_IDLE),
    .FRAME_GAP   (FRAME_GAP),
    .CFG_W       (CFG_W),
    .TMO_W       (TMO_W)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .abort       (abort),
    .num_frames  (num_frames),
    .cfg_in      (cfg_in),
    .cfg_active  (cfg_active),
    .src_begin   (src_begin),
    .src_done    (src_done),
    .post_valid  (post_valid),
    .busy        (busy),
    .frame_idx   (frame_idx),
    .frame_tick  (frame_tick),
    .seq_done    (seq_done),
    .timeout_err (timeout_err)
  );

  // Passive monitor: event counts and pulse-width bookkeeping, sampled on the falling edge.
  always @(negedge clk) begin
    cyc = cyc + 1;
    if (src_begin === 1'b1 && !sb_q) begin_cnt = begin_cnt + 1;
    if (src_begin === 1'b1) begin
      cur_len = cur_len + 1;
    end else begin
      if (sb_q && cur_len != BEGIN_PULSE) bad_len = bad_len + 1;
      cur_len = 0;
    end
    if (frame_tick === 1'b1) begin
      tick_idx[tick_cnt % 256] = frame_idx;
      last_tick_cyc = cyc;
      tick_cnt = tick_cnt + 1;
    end
    if (seq_done === 1'b1) done_cnt = done_cnt + 1;
    sb_q = (src_begin === 1'b1);
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  // Frame source + filter output model: src_done pulse done_delay cycles after each begin.
  initial begin
    src_done   = 1'b0;
    post_valid = 1'b0;
    forever begin
      step();
      if (src_begin === 1'b1 && !m_prev && src_en) begin
        repeat (done_delay) step();
        src_done = 1'b1;
        step();
        src_done = 1'b0;
        if (toggle_mode) begin
          for (int k = 0; k < 2; k++) begin
            repeat (30) step();
            post_valid = 1'b1;
            repeat (30) step();
            post_valid = 1'b0;
          end
          pv_fall_cyc = cyc;
        end else begin
          repeat (burst_pre) step();
          post_valid = 1'b1;
          repeat (burst_len) step();
          post_valid = 1'b0;
        end
      end
      m_prev = src_begin;
    end
  end

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) step();
    checks++; if (cfg_active !== '0) begin errors++; $display("FAIL reset_cfg_active: got %h want 0", cfg_active); end
    checks++; if (src_begin !== 1'b0) begin errors++; $display("FAIL reset_src_begin: got %b want 0", src_begin); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
    checks++; if (frame_idx !== 8'd0) begin errors++; $display("FAIL reset_frame_idx: got %0d want 0", frame_idx); end
    checks++; if (frame_tick !== 1'b0) begin errors++; $display("FAIL reset_frame_tick: got %b want 0", frame_tick); end
    checks++; if (seq_done !== 1'b0) begin errors++; $display("FAIL reset_seq_done: got %b want 0", seq_done); end
    checks++; if (timeout_err !== 1'b0) begin errors++; $display("FAIL reset_timeout_err: got %b want 0", timeout_err); end
    rst = 1'b0;
    repeat (2) step();
  endtask

  task automatic test_multi_frame();
    int b0, t0, s0, bl0, n;
    b0 = begin_cnt; t0 = tick_cnt; s0 = done_cnt; bl0 = bad_len;
    done_delay = 100; burst_pre = 5; burst_len = 10; toggle_mode = 1'b0; src_en = 1'b1;
    num_frames = 8'd3; cfg_in = 4'h2;
    start = 1'b1; step(); start = 1'b0;
    checks++; if (busy !== 1'b1 || src_begin !== 1'b0) begin errors++; $display("FAIL mf_load_cycle: busy=%b src_begin=%b want 1/0", busy, src_begin); end
    step();
    checks++; if (src_begin !== 1'b1) begin errors++; $display("FAIL mf_start_latency: src_begin=%b want 1", src_begin); end
    start = 1'b1; step(); start = 1'b0;
    n = 0;
    while (busy !== 1'b0 && n < 3000) begin step(); n++; end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL mf_run_end: busy=%b after %0d cycles want 0", busy, n); end
    checks++; if (begin_cnt - b0 !== 3) begin errors++; $display("FAIL mf_begin_count: got %0d want 3", begin_cnt - b0); end
    checks++; if (bad_len !== bl0) begin errors++; $display("FAIL mf_pulse_width: %0d pulses not %0d cycles", bad_len - bl0, BEGIN_PULSE); end
    checks++; if (tick_cnt - t0 !== 3) begin errors++; $display("FAIL mf_tick_count: got %0d want 3", tick_cnt - t0); end
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (tick_idx[(t0 + i) % 256] !== 8'(i)) begin
        errors++; $display("FAIL mf_tick_idx%0d: got %0d want %0d", i, tick_idx[(t0 + i) % 256], i);
      end
    end
    checks++; if (done_cnt - s0 !== 1) begin errors++; $display("FAIL mf_seq_done: got %0d want 1", done_cnt - s0); end
    checks++; if (frame_idx !== 8'd2) begin errors++; $display("FAIL mf_final_idx: got %0d want 2", frame_idx); end
    checks++; if (cfg_active !== 4'h2) begin errors++; $display("FAIL mf_cfg: got %h want 2", cfg_active); end
    repeat (5) step();
  endtask

  task automatic test_cfg_shadow();
    int b0, t0, s0, n;
    b0 = begin_cnt; t0 = tick_cnt; s0 = done_cnt;
    done_delay = 20; burst_pre = 3; burst_len = 4;
    num_frames = 8'd2; cfg_in = 4'h4;
    start = 1'b1; step(); start = 1'b0;
    n = 0; while (begin_cnt < b0 + 1 && n < 20) begin step(); n++; end
    cfg_in = 4'h9;
    repeat (10) step();
    checks++; if (cfg_active !== 4'h4) begin errors++; $display("FAIL cfg_mid_frame0: got %h want 4", cfg_active); end
    n = 0; while (tick_cnt < t0 + 1 && n < 400) begin step(); n++; end
    checks++; if (cfg_active !== 4'h4) begin errors++; $display("FAIL cfg_at_drain0: got %h want 4", cfg_active); end
    repeat (8) step();
    checks++; if (cfg_active !== 4'h4) begin errors++; $display("FAIL cfg_in_gap: got %h want 4", cfg_active); end
    n = 0; while (begin_cnt < b0 + 2 && n < 100) begin step(); n++; end
    checks++; if (cfg_active !== 4'h9) begin errors++; $display("FAIL cfg_frame1: got %h want 9", cfg_active); end
    n = 0; while (busy !== 1'b0 && n < 1000) begin step(); n++; end
    checks++; if (done_cnt - s0 !== 1 || busy !== 1'b0) begin errors++; $display("FAIL cfg_run_end: seq_done=%0d busy=%b want 1/0", done_cnt - s0, busy); end
    repeat (5) step();
  endtask

  task automatic test_abort_continuous();
    int b0, t0, s0, n;
    b0 = begin_cnt; t0 = tick_cnt; s0 = done_cnt;
    done_delay = 10; burst_pre = 2; burst_len = 3;
    num_frames = 8'd0; cfg_in = 4'h1;
    start = 1'b1; step(); start = 1'b0;
    n = 0; while (begin_cnt < b0 + 6 && n < 1500) begin step(); n++; end
    repeat (7) step();
    checks++; if (frame_idx !== 8'd5) begin errors++; $display("FAIL ab_frame_idx: got %0d want 5", frame_idx); end
    abort = 1'b1; step(); abort = 1'b0;
    n = 0; while (busy !== 1'b0 && n < 500) begin step(); n++; end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL ab_busy: got %b want 0", busy); end
    checks++; if (tick_cnt - t0 !== 6) begin errors++; $display("FAIL ab_tick_count: got %0d want 6", tick_cnt - t0); end
    checks++; if (tick_idx[(t0 + 5) % 256] !== 8'd5) begin errors++; $display("FAIL ab_last_tick_idx: got %0d want 5", tick_idx[(t0 + 5) % 256]); end
    checks++; if (done_cnt !== s0) begin errors++; $display("FAIL ab_no_seq_done: got %0d want 0", done_cnt - s0); end
    repeat (100) step();
    checks++; if (begin_cnt - b0 !== 6) begin errors++; $display("FAIL ab_begin_count: got %0d want 6", begin_cnt - b0); end
  endtask

  task automatic test_timeout();
    int s0, n;
    s0 = done_cnt;
    src_en = 1'b0;
    num_frames = 8'd1;
    start = 1'b1; step(); start = 1'b0;
    n = 0; while (src_begin !== 1'b1 && n < 10) begin step(); n++; end
    n = 0; while (timeout_err !== 1'b1 && n < 400) begin step(); n++; end
    checks++; if (n !== 255) begin errors++; $display("FAIL tmo_cycles: timeout after %0d cycles want 255", n); end
    checks++; if (busy !== 1'b0 || src_begin !== 1'b0) begin errors++; $display("FAIL tmo_idle: busy=%b src_begin=%b want 0/0", busy, src_begin); end
    repeat (20) step();
    checks++; if (timeout_err !== 1'b1) begin errors++; $display("FAIL tmo_sticky: got %b want 1", timeout_err); end
    checks++; if (done_cnt !== s0) begin errors++; $display("FAIL tmo_no_seq_done: got %0d want 0", done_cnt - s0); end
    src_en = 1'b1; done_delay = 10; burst_pre = 2; burst_len = 3;
    start = 1'b1; step(); start = 1'b0;
    checks++; if (timeout_err !== 1'b0) begin errors++; $display("FAIL tmo_clear: got %b want 0", timeout_err); end
    n = 0; while (busy !== 1'b0 && n < 500) begin step(); n++; end
    checks++; if (done_cnt - s0 !== 1 || timeout_err !== 1'b0) begin errors++; $display("FAIL tmo_rerun: seq_done=%0d timeout_err=%b want 1/0", done_cnt - s0, timeout_err); end
    repeat (5) step();
  endtask

  task automatic test_drain_toggle();
    int t0, s0, n;
    t0 = tick_cnt; s0 = done_cnt;
    done_delay = 10; toggle_mode = 1'b1; pv_fall_cyc = 0;
    num_frames = 8'd1;
    start = 1'b1; step(); start = 1'b0;
    n = 0; while (busy !== 1'b0 && n < 600) begin step(); n++; end
    checks++; if (tick_cnt - t0 !== 1) begin errors++; $display("FAIL dt_tick_count: got %0d want 1", tick_cnt - t0); end
    checks++; if (pv_fall_cyc == 0 || last_tick_cyc - pv_fall_cyc !== DRAIN_IDLE) begin
      errors++; $display("FAIL dt_quiet_run: tick %0d cycles after last valid, want %0d", last_tick_cyc - pv_fall_cyc, DRAIN_IDLE);
    end
    checks++; if (done_cnt - s0 !== 1) begin errors++; $display("FAIL dt_seq_done: got %0d want 1", done_cnt - s0); end
    toggle_mode = 1'b0;
    repeat (5) step();
  endtask

  task automatic test_reset_mid_run();
    int b0, t0, s0, bl0, n;
    done_delay = 100; burst_pre = 5; burst_len = 10;
    num_frames = 8'd1; cfg_in = 4'hA;
    start = 1'b1; step(); start = 1'b0;
    n = 0; while (src_begin !== 1'b1 && n < 10) begin step(); n++; end
    step();
    checks++; if (src_begin !== 1'b1 || cfg_active !== 4'hA) begin errors++; $display("FAIL rr_pre: src_begin=%b cfg=%h want 1/a", src_begin, cfg_active); end
    #2 rst = 1'b1;
    #1;
    checks++; if (src_begin !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL rr_async: src_begin=%b busy=%b want 0/0", src_begin, busy); end
    checks++; if (cfg_active !== '0) begin errors++; $display("FAIL rr_cfg: got %h want 0", cfg_active); end
    step(); rst = 1'b0;
    repeat (200) step();
    b0 = begin_cnt; t0 = tick_cnt; s0 = done_cnt; bl0 = bad_len;
    num_frames = 8'd3; cfg_in = 4'h2;
    start = 1'b1; step(); start = 1'b0;
    step();
    checks++; if (src_begin !== 1'b1) begin errors++; $display("FAIL rr_latency: src_begin=%b want 1", src_begin); end
    n = 0; while (busy !== 1'b0 && n < 3000) begin step(); n++; end
    checks++; if (begin_cnt - b0 !== 3 || bad_len !== bl0) begin errors++; $display("FAIL rr_begins: got %0d pulses (%0d bad) want 3 (0 bad)", begin_cnt - b0, bad_len - bl0); end
    checks++; if (tick_cnt - t0 !== 3 || tick_idx[(t0 + 2) % 256] !== 8'd2) begin errors++; $display("FAIL rr_ticks: got %0d ticks last idx %0d want 3/2", tick_cnt - t0, tick_idx[(t0 + 2) % 256]); end
    checks++; if (done_cnt - s0 !== 1) begin errors++; $display("FAIL rr_seq_done: got %0d want 1", done_cnt - s0); end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; abort = 1'b0; num_frames = 8'd0; cfg_in = '0;
    test_reset();
    test_multi_frame();
    test_cfg_shadow();
    test_abort_continuous();
    test_timeout();
    test_drain_toggle();
    test_reset_mid_run();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
